// File: rtl/vm_coffee_if.sv
// Payment/supply inputs and dispense/fault outputs of the coffee vending controller.
interface vm_coffee_if;
  logic       C5;
  logic       C10;
  logic       NFC;
  logic [4:0] WATER;
  logic       BEANS;
  logic       COFFEE;
  logic       ERROR;

  modport master (output C5, C10, NFC, WATER, BEANS, input COFFEE, ERROR);
  modport slave  (input C5, C10, NFC, WATER, BEANS, output COFFEE, ERROR);
endinterface

// File: rtl/vm_coffee.sv
// Coffee vending controller: collects coin/card payment, checks supply, then
// pulses COFFEE while dispensing or ERROR on a supply fault.
//
// state | meaning
// IDLE  | accumulating coin credit, waiting for full payment or card
// CHECK | one cycle: sample WATER/BEANS, clear credit
// BREW  | COFFEE high for BREW_CYCLES cycles
// ERR   | ERROR high for ERROR_CYCLES cycles, credit forfeited
module vm_coffee #(
  parameter int unsigned PRICE        = 10,
  parameter int unsigned WATER_MIN    = 5,
  parameter int unsigned BREW_CYCLES  = 4,
  parameter int unsigned ERROR_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  vm_coffee_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, CHECK, BREW, ERR} state_t;

  localparam logic [4:0] PRICE_W     = 5'(PRICE);
  localparam logic [4:0] WATER_MIN_W = 5'(WATER_MIN);
  localparam logic [2:0] BREW_LOAD   = 3'(BREW_CYCLES - 1);
  localparam logic [2:0] ERR_LOAD    = 3'(ERROR_CYCLES - 1);

  state_t     state_q, state_d;
  logic [4:0] credit_q, credit_d;
  logic [2:0] tmr_q, tmr_d;
  logic       prev_c5, prev_c10, prev_nfc;
  logic       coffee_q, coffee_d;
  logic       error_q, error_d;

  logic       ev_c5, ev_c10, ev_nfc;
  logic [4:0] credit_sum;
  logic       supply_ok;

  assign ev_c5      = bus.C5  & ~prev_c5;
  assign ev_c10     = bus.C10 & ~prev_c10;
  assign ev_nfc     = bus.NFC & ~prev_nfc;
  assign credit_sum = credit_q + (ev_c5 ? 5'd5 : 5'd0) + (ev_c10 ? 5'd10 : 5'd0);
  assign supply_ok  = (bus.WATER >= WATER_MIN_W) & bus.BEANS;

  // Edge registers track the inputs in every state so held levels never re-trigger.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      credit_q <= '0;
      tmr_q    <= '0;
      prev_c5  <= 1'b0;
      prev_c10 <= 1'b0;
      prev_nfc <= 1'b0;
      coffee_q <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      tmr_q    <= tmr_d;
      prev_c5  <= bus.C5;
      prev_c10 <= bus.C10;
      prev_nfc <= bus.NFC;
      coffee_q <= coffee_d;
      error_q  <= error_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    tmr_d    = tmr_q;
    unique case (state_q)
      IDLE: begin
        credit_d = credit_sum;
        if ((credit_sum >= PRICE_W) || ev_nfc) state_d = CHECK;
      end
      CHECK: begin
        credit_d = '0;
        if (supply_ok) begin
          state_d = BREW;
          tmr_d   = BREW_LOAD;
        end else begin
          state_d = ERR;
          tmr_d   = ERR_LOAD;
        end
      end
      BREW, ERR: begin
        if (tmr_q == 3'd0) state_d = IDLE;
        else               tmr_d   = tmr_q - 3'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from the next state and registered, so they align with the state.
  always_comb begin
    coffee_d = (state_d == BREW);
    error_d  = (state_d == ERR);
  end

  assign bus.COFFEE = coffee_q;
  assign bus.ERROR  = error_q;

endmodule

// File: tb/tb_vm_coffee.sv
// Bench for vm_coffee: directed scenarios then random traffic, all checked each
// cycle against a schedule-based reference model.
module tb_vm_coffee;
  logic clk = 1'b0;
  logic rst;
  vm_coffee_if bus ();

  vm_coffee dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: payments open a window of dispense/fault cycles on an edge timeline.
  int ncyc = 0;
  int m_credit, m_check, m_free, m_lo, m_hi;
  bit m_brew, p5, p10, pn;
  bit exp_cof, exp_err;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s cycle %0d got %0d exp %0d", tag, ncyc, got, exp);
    end
  endtask

  task automatic model_step();
    bit e5, e10, en, in_win;
    int len;
    if (rst) begin
      m_credit = 0; m_check = -1; m_free = 0; m_lo = 1; m_hi = 0; m_brew = 0;
      p5 = 0; p10 = 0; pn = 0;
    end else begin
      e5  = bus.C5  && !p5;
      e10 = bus.C10 && !p10;
      en  = bus.NFC && !pn;
      if (ncyc == m_check) begin
        m_brew   = (bus.WATER >= 5) && bus.BEANS;
        len      = m_brew ? 4 : 2;
        m_lo     = ncyc;
        m_hi     = ncyc + len - 1;
        m_free   = ncyc + len + 1;
        m_credit = 0;
      end else if (ncyc >= m_free) begin
        m_credit += 5 * int'(e5) + 10 * int'(e10);
        if (m_credit >= 10 || en) begin
          m_check = ncyc + 1;
          m_free  = ncyc + 2;
        end
      end
      p5 = bus.C5; p10 = bus.C10; pn = bus.NFC;
    end
    in_win  = !rst && ncyc >= m_lo && ncyc <= m_hi;
    exp_cof = in_win && m_brew;
    exp_err = in_win && !m_brew;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_step();
      #1;
      chk("coffee", int'(bus.COFFEE), int'(exp_cof));
      chk("error",  int'(bus.ERROR),  int'(exp_err));
      chk("credit", int'(dut.credit_q), m_credit);
      ncyc++;
    end
  endtask

  task automatic set_in(input bit c5, input bit c10, input bit nfc,
                        input logic [4:0] water, input bit beans);
    bus.C5 = c5; bus.C10 = c10; bus.NFC = nfc; bus.WATER = water; bus.BEANS = beans;
  endtask

  initial begin
    rst = 1'b1;
    set_in(0, 0, 0, 5'd0, 1'b0);
    run(2);
    rst = 1'b0;
    // no water: fault pulse
    set_in(0, 1, 0, 5'd0, 1); run(1);
    set_in(0, 0, 0, 5'd0, 1); run(6);
    // no beans: C5 then C10
    set_in(1, 0, 0, 5'd5, 0); run(1);
    set_in(0, 0, 0, 5'd5, 0); run(1);
    set_in(0, 1, 0, 5'd5, 0); run(1);
    set_in(0, 0, 0, 5'd5, 0); run(6);
    // two separate C5 pulses, minimum water
    set_in(1, 0, 0, 5'd5, 1); run(1);
    set_in(0, 0, 0, 5'd5, 1); run(2);
    set_in(1, 0, 0, 5'd5, 1); run(1);
    set_in(0, 0, 0, 5'd5, 1); run(8);
    // card payment, then C10 held 10 cycles
    set_in(0, 0, 1, 5'd31, 1); run(1);
    set_in(0, 0, 0, 5'd31, 1); run(8);
    set_in(0, 1, 0, 5'd31, 1); run(10);
    set_in(0, 0, 0, 5'd31, 1); run(6);
    // simultaneous coins, then a lone C5 leaves credit 5
    set_in(1, 1, 0, 5'd20, 1); run(1);
    set_in(0, 0, 0, 5'd20, 1); run(8);
    set_in(1, 0, 0, 5'd20, 1); run(1);
    set_in(0, 0, 0, 5'd20, 1); run(4);
    // water just below minimum
    set_in(0, 1, 0, 5'd4, 1); run(1);
    set_in(0, 0, 0, 5'd4, 1); run(6);
    // reset during brew
    set_in(0, 1, 0, 5'd31, 1); run(3);
    set_in(0, 0, 0, 5'd31, 1);
    rst = 1'b1; run(1);
    rst = 1'b0; run(3);
    // level held through reset counts on first edge after release
    set_in(0, 1, 0, 5'd31, 1);
    rst = 1'b1; run(2);
    rst = 1'b0; run(8);
    set_in(0, 0, 0, 5'd31, 1); run(2);

    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 3) == 0) bus.C5  = ~bus.C5;
      if ($urandom_range(0, 4) == 0) bus.C10 = ~bus.C10;
      if ($urandom_range(0, 9) == 0) bus.NFC = ~bus.NFC;
      if ($urandom_range(0, 7) == 0) bus.WATER = 5'($urandom_range(0, 31));
      else if ($urandom_range(0, 7) == 0) bus.WATER = 5'($urandom_range(3, 7));
      if ($urandom_range(0, 5) == 0) bus.BEANS = ($urandom_range(0, 4) != 0);
      rst = ($urandom_range(0, 199) == 0);
      run(1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
